// File: rtl/dram_cmd_arbiter_pkg.sv
// rtl/dram_cmd_arbiter_pkg.sv - shared DRAM command widths, limits and types
package dram_cmd_arbiter_pkg;

  localparam int GLOBAL_ADDR_BW  = 32;
  localparam int DATA_BW         = 8;
  localparam int CACHE_SIZE      = 4;
  localparam int DRAM_MAX_RD_OUT = 4;

  // Command word as seen by the memory-controller side
  typedef struct packed {
    logic                             we;
    logic [GLOBAL_ADDR_BW-1:0]        addr;
    logic [DATA_BW*CACHE_SIZE-1:0]    wd;
    logic [CACHE_SIZE-1:0]            mask;
  } dram_cmd_t;

  typedef enum logic {
    SLICE_EMPTY = 1'b0,
    SLICE_FULL  = 1'b1
  } slice_state_e;

endpackage

// File: rtl/dram_cmd_rr_pick.sv
// rtl/dram_cmd_rr_pick.sv - weighted round-robin read/write pick with run tracking
module dram_cmd_rr_pick #(
  parameter int WR_WEIGHT = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_slot_free,
  input  logic i_rd_ok,
  input  logic i_wr_rdy,
  output logic o_gnt_rd,
  output logic o_gnt_wr
);

  localparam int RW = $clog2(WR_WEIGHT + 1);
  localparam logic [RW-1:0] RUN_CAP = RW'(WR_WEIGHT);

  logic          last_wr_q, last_wr_d;
  logic [RW-1:0] wr_run_q, wr_run_d;
  logic          pick_wr;

  // Reset leaves last_wr_q as "read", so a contended first pick goes to the write
  assign pick_wr  = i_wr_rdy && (!i_rd_ok || !last_wr_q || (wr_run_q < RUN_CAP));
  assign o_gnt_wr = i_slot_free && pick_wr;
  assign o_gnt_rd = i_slot_free && i_rd_ok && !pick_wr;

  always_comb begin
    last_wr_d = last_wr_q;
    wr_run_d  = wr_run_q;
    if (o_gnt_wr) begin
      last_wr_d = 1'b1;
      if (!last_wr_q) begin
        wr_run_d = RW'(1);
      end else if (wr_run_q < RUN_CAP) begin
        wr_run_d = wr_run_q + RW'(1);
      end
    end else if (o_gnt_rd) begin
      last_wr_d = 1'b0;
      wr_run_d  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_wr_q <= 1'b0;
      wr_run_q  <= '0;
    end else begin
      last_wr_q <= last_wr_d;
      wr_run_q  <= wr_run_d;
    end
  end

endmodule

// File: rtl/dram_cmd_arbiter.sv
// rtl/dram_cmd_arbiter.sv - merges read and write requesters onto one DRAM command slice
module dram_cmd_arbiter
  import dram_cmd_arbiter_pkg::*;
#(
  parameter int GBW        = GLOBAL_ADDR_BW,
  parameter int DBW        = DATA_BW,
  parameter int CSIZE      = CACHE_SIZE,
  parameter int MAX_RD_OUT = DRAM_MAX_RD_OUT,
  parameter int WR_WEIGHT  = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_dramra_rdy,
  output logic                         o_dramra_ack,
  input  logic [GBW-1:0]               i_dramra,
  input  logic                         i_dramw_rdy,
  output logic                         o_dramw_ack,
  input  logic [GBW-1:0]               i_dramwa,
  input  logic [DBW*CSIZE-1:0]         i_dramwd,
  input  logic [CSIZE-1:0]             i_dramw_mask,
  output logic                         o_cmd_rdy,
  input  logic                         i_cmd_ack,
  output logic                         o_cmd_we,
  output logic [GBW-1:0]               o_cmd_addr,
  output logic [DBW*CSIZE-1:0]         o_cmd_wd,
  output logic [CSIZE-1:0]             o_cmd_mask,
  input  logic                         i_dramrd_rdy,
  input  logic                         i_dramrd_ack,
  output logic [$clog2(MAX_RD_OUT+1)-1:0] o_rd_inflight,
  output logic                         o_err
);

  localparam int IW = $clog2(MAX_RD_OUT + 1);
  localparam logic [IW-1:0] RD_CAP = IW'(MAX_RD_OUT);

  slice_state_e           state_q, state_d;
  logic                   we_q, we_d;
  logic [GBW-1:0]         addr_q, addr_d;
  logic [DBW*CSIZE-1:0]   wd_q, wd_d;
  logic [CSIZE-1:0]       mask_q, mask_d;
  logic [IW-1:0]          inflight_q, inflight_d;
  logic                   err_q, err_d;

  logic slot_free, rd_ok, gnt_rd, gnt_wr, rd_ret;

  // Grants are held off while reset is asserted so no ack escapes during reset
  assign slot_free = i_rst_n && ((state_q == SLICE_EMPTY) || i_cmd_ack);
  assign rd_ok     = i_dramra_rdy && (inflight_q < RD_CAP);
  assign rd_ret    = i_dramrd_rdy && i_dramrd_ack;

  dram_cmd_rr_pick #(
    .WR_WEIGHT (WR_WEIGHT)
  ) u_pick (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_slot_free (slot_free),
    .i_rd_ok     (rd_ok),
    .i_wr_rdy    (i_dramw_rdy),
    .o_gnt_rd    (gnt_rd),
    .o_gnt_wr    (gnt_wr)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    mask_d  = mask_q;
    if (gnt_wr) begin
      state_d = SLICE_FULL;
      we_d    = 1'b1;
      addr_d  = i_dramwa;
      wd_d    = i_dramwd;
      mask_d  = i_dramw_mask;
    end else if (gnt_rd) begin
      state_d = SLICE_FULL;
      we_d    = 1'b0;
      addr_d  = i_dramra;
      wd_d    = '0;
      mask_d  = '0;
    end else if ((state_q == SLICE_FULL) && i_cmd_ack) begin
      state_d = SLICE_EMPTY;
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    if (rd_ret && (inflight_q == '0)) begin
      err_d = 1'b1;
    end
    if (gnt_rd && !rd_ret) begin
      inflight_d = inflight_q + IW'(1);
    end else if (rd_ret && !gnt_rd && (inflight_q != '0)) begin
      inflight_d = inflight_q - IW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= SLICE_EMPTY;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wd_q       <= '0;
      mask_q     <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wd_q       <= wd_d;
      mask_q     <= mask_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign o_dramra_ack  = gnt_rd;
  assign o_dramw_ack   = gnt_wr;
  assign o_cmd_rdy     = (state_q == SLICE_FULL);
  assign o_cmd_we      = we_q;
  assign o_cmd_addr    = addr_q;
  assign o_cmd_wd      = wd_q;
  assign o_cmd_mask    = mask_q;
  assign o_rd_inflight = inflight_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_dram_cmd_arbiter.sv
// tb/tb_dram_cmd_arbiter.sv - directed self-checking bench for dram_cmd_arbiter
module tb_dram_cmd_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ra_rdy, ra_ack, w_rdy, w_ack;
  logic [31:0] ra, wa, wd;
  logic [3:0]  wmask;
  logic        cmd_rdy, cmd_ack, cmd_we;
  logic [31:0] cmd_addr, cmd_wd;
  logic [3:0]  cmd_mask;
  logic        rd_rdy, rd_ack;
  logic [2:0]  inflight;
  logic        err;

  int vectors;
  int miscompares;
  int acks;

  dram_cmd_arbiter dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_dramra_rdy  (ra_rdy),
    .o_dramra_ack  (ra_ack),
    .i_dramra      (ra),
    .i_dramw_rdy   (w_rdy),
    .o_dramw_ack   (w_ack),
    .i_dramwa      (wa),
    .i_dramwd      (wd),
    .i_dramw_mask  (wmask),
    .o_cmd_rdy     (cmd_rdy),
    .i_cmd_ack     (cmd_ack),
    .o_cmd_we      (cmd_we),
    .o_cmd_addr    (cmd_addr),
    .o_cmd_wd      (cmd_wd),
    .o_cmd_mask    (cmd_mask),
    .i_dramrd_rdy  (rd_rdy),
    .i_dramrd_ack  (rd_ack),
    .o_rd_inflight (inflight),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    ra_rdy = 1'b0; ra = '0;
    w_rdy = 1'b0; wa = '0; wd = '0; wmask = '0;
    cmd_ack = 1'b1;
    rd_rdy = 1'b0; rd_ack = 1'b0;

    #1;
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", cmd_addr, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single read
    ra_rdy = 1'b1; ra = 32'h40;
    #1;
    chk("rd1_ra_ack", ra_ack, 1);
    chk("rd1_w_ack", w_ack, 0);
    @(negedge clk);
    ra_rdy = 1'b0;
    chk("rd1_cmd_rdy", cmd_rdy, 1);
    chk("rd1_we", cmd_we, 0);
    chk("rd1_addr", cmd_addr, 32'h40);
    chk("rd1_wd", cmd_wd, 0);
    chk("rd1_mask", cmd_mask, 0);
    chk("rd1_inflight", inflight, 1);
    rd_rdy = 1'b1; rd_ack = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0; rd_ack = 1'b0;
    chk("rd1_ret_inflight", inflight, 0);
    chk("rd1_drained", cmd_rdy, 0);

    // contention: W,W,R,W,W,R with no bubbles
    ra_rdy = 1'b1; ra = 32'h80;
    w_rdy = 1'b1; wa = 32'h200; wd = 32'h1234_5678; wmask = 4'hF;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("cont_w_ack", w_ack, (i % 3) != 2);
      chk("cont_ra_ack", ra_ack, (i % 3) == 2);
      @(negedge clk);
      chk("cont_cmd_rdy", cmd_rdy, 1);
      chk("cont_we", cmd_we, (i % 3) != 2);
    end
    ra_rdy = 1'b0; w_rdy = 1'b0;
    chk("cont_inflight", inflight, 2);
    rd_rdy = 1'b1; rd_ack = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_rdy = 1'b0; rd_ack = 1'b0;
    chk("cont_ret_inflight", inflight, 0);

    // credit cap: six reads offered, four accepted
    ra_rdy = 1'b1; ra = 32'h300;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (ra_ack) acks++;
      @(negedge clk);
    end
    chk("cap_acks", acks, 4);
    chk("cap_inflight", inflight, 4);
    w_rdy = 1'b1; wa = 32'h400; wd = 32'hDEAD_BEEF; wmask = 4'hA;
    #1;
    chk("cap_w_ack", w_ack, 1);
    chk("cap_ra_ack", ra_ack, 0);
    @(negedge clk);
    w_rdy = 1'b0;
    chk("cap_we", cmd_we, 1);
    chk("cap_addr", cmd_addr, 32'h400);
    chk("cap_wd", cmd_wd, 32'hDEAD_BEEF);
    chk("cap_mask", cmd_mask, 4'hA);

    // credit release, then grant and return together
    rd_rdy = 1'b1; rd_ack = 1'b1;
    #1;
    chk("rel_ra_ack_blocked", ra_ack, 0);
    @(negedge clk);
    chk("rel_inflight3", inflight, 3);
    #1;
    chk("rel_ra_ack", ra_ack, 1);
    @(negedge clk);
    chk("rel_same_cycle", inflight, 3);
    rd_rdy = 1'b0; rd_ack = 1'b0;
    #1;
    chk("rel_ra_ack2", ra_ack, 1);
    @(negedge clk);
    chk("rel_inflight4", inflight, 4);

    // backpressure: slice holds read 0x300, write waits
    cmd_ack = 1'b0;
    w_rdy = 1'b1; wa = 32'h500; wd = 32'h0BAD_F00D; wmask = 4'h3;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_w_ack", w_ack, 0);
      chk("bp_ra_ack", ra_ack, 0);
      @(negedge clk);
      chk("bp_cmd_rdy", cmd_rdy, 1);
      chk("bp_we", cmd_we, 0);
      chk("bp_addr", cmd_addr, 32'h300);
    end
    cmd_ack = 1'b1;
    #1;
    chk("bp_refill_ack", w_ack, 1);
    @(negedge clk);
    w_rdy = 1'b0; ra_rdy = 1'b0;
    chk("bp_refill_we", cmd_we, 1);
    chk("bp_refill_addr", cmd_addr, 32'h500);

    // drain credits, then a spurious return
    rd_rdy = 1'b1; rd_ack = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("err_pre_inflight", inflight, 0);
    chk("err_pre", err, 0);
    @(negedge clk);
    chk("err_set", err, 1);
    chk("err_inflight", inflight, 0);
    rd_rdy = 1'b0; rd_ack = 1'b0;
    @(negedge clk);
    chk("err_sticky", err, 1);

    // reset mid-operation with a write pending
    ra_rdy = 1'b1; ra = 32'h600;
    #1;
    chk("mid_ra_ack", ra_ack, 1);
    @(negedge clk);
    ra_rdy = 1'b0;
    w_rdy = 1'b1; wa = 32'h100; wd = 32'hCAFE_F00D; wmask = 4'h5;
    #1;
    chk("mid_w_ack", w_ack, 1);
    @(negedge clk);
    cmd_ack = 1'b0;
    chk("mid_cmd_rdy", cmd_rdy, 1);
    chk("mid_addr", cmd_addr, 32'h100);
    chk("mid_inflight", inflight, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd_rdy", cmd_rdy, 0);
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_w_ack", w_ack, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_regrant_ack", w_ack, 1);
    @(negedge clk);
    chk("mid_re_cmd_rdy", cmd_rdy, 1);
    chk("mid_re_we", cmd_we, 1);
    chk("mid_re_addr", cmd_addr, 32'h100);
    chk("mid_re_wd", cmd_wd, 32'hCAFE_F00D);
    chk("mid_re_mask", cmd_mask, 4'h5);
    w_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
